// File: rtl/hdmi_panel_io_ctrl.sv
// Front-panel I/O controller: synchronised, debounced switch channels with
// edge pulses, and registered LED drivers with off/on/follow/blink modes.
module hdmi_panel_io_ctrl #(
    parameter int N_SW            = 4,
    parameter int N_LED           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1250000,
    parameter int BLINK_CYCLES    = 31250000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_SW-1:0]    sw,
    input  logic [N_LED-1:0]   status,
    input  logic [2*N_LED-1:0] led_mode,
    output logic [N_SW-1:0]    sw_db,
    output logic [N_SW-1:0]    sw_rise,
    output logic [N_SW-1:0]    sw_fall,
    output logic [N_LED-1:0]   led,
    output logic               blink_phase
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int BK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BK_W-1:0] BK_LAST = BK_W'(BLINK_CYCLES - 1);

    typedef enum logic [1:0] {
        LED_OFF    = 2'b00,
        LED_ON     = 2'b01,
        LED_FOLLOW = 2'b10,
        LED_BLINK  = 2'b11
    } led_mode_e;

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        logic [SYNC_STAGES-1:0] sync;
        logic [DB_W-1:0]        cnt;
        logic                   db;
        logic                   rise;
        logic                   fall;
        logic                   s;

        assign s          = sync[SYNC_STAGES-1];
        assign sw_db[i]   = db;
        assign sw_rise[i] = rise;
        assign sw_fall[i] = fall;

        // Any disagreement between the synchronised pin and the accepted level
        // must persist DEBOUNCE_CYCLES edges in a row; one agreeing sample restarts it.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync <= '0;
                cnt  <= '0;
                db   <= 1'b0;
                rise <= 1'b0;
                fall <= 1'b0;
            end else begin
                // NOTE: non-blocking assignments keep every flop sampling the
                // pre-edge value, which is what makes the shift chain a chain.
                sync <= {sync[SYNC_STAGES-2:0], sw[i]};
                rise <= 1'b0;
                fall <= 1'b0;
                if (s == db) begin
                    cnt <= '0;
                end else if (cnt == DB_LAST) begin
                    db   <= s;
                    cnt  <= '0;
                    rise <= s;
                    fall <= ~s;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    logic [BK_W-1:0] blink_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    logic [N_LED-1:0] led_next;

    always_comb begin
        // NOTE: default first so every path assigns led_next and no latch is inferred.
        led_next = '0;
        for (int i = 0; i < N_LED; i++) begin
            case (led_mode_e'(led_mode[2*i +: 2]))
                LED_OFF:    led_next[i] = 1'b0;
                LED_ON:     led_next[i] = 1'b1;
                LED_FOLLOW: led_next[i] = status[i];
                LED_BLINK:  led_next[i] = status[i] & blink_phase;
                default:    led_next[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) led <= '0;
        else     led <= led_next;
    end

endmodule
